// File: rtl/pci_phy_pkg.sv
// ---------------------------------------------------------------------------
// pci_phy_pkg
//   Shared widths, symbol constants and FSM state type for the PCI PHY
//   lane-path serializer (mux_32_8) and its interface.
//   No ports.
// ---------------------------------------------------------------------------
package pci_phy_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    localparam logic [7:0] COM_BYTE = 8'hBC;
    localparam logic [7:0] IDLE_PAD = 8'h00;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/mux_32_8_if.sv
// ---------------------------------------------------------------------------
// mux_32_8_if
//   Word-in / byte-out bus of the serializer.
//   data_in   : word offered by the source
//   valid_in  : data_in holds a word
//   ready_in  : serializer can take a word this cycle
//   data_out  : serialized byte
//   valid_out : data_out carries a payload byte
//   master = word source / byte sink, slave = serializer.
// ---------------------------------------------------------------------------
interface mux_32_8_if;

    logic [pci_phy_pkg::WORD_W-1:0] data_in;
    logic                           valid_in;
    logic                           ready_in;
    logic [pci_phy_pkg::BYTE_W-1:0] data_out;
    logic                           valid_out;

    modport master (
        output data_in,
        output valid_in,
        input  ready_in,
        input  data_out,
        input  valid_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_in,
        output data_out,
        output valid_out
    );

endinterface

// File: rtl/mux_32_8_hold.sv
// ---------------------------------------------------------------------------
// mux_32_8_hold
//   One-entry word buffer with a full flag, sitting between the input
//   handshake and the shifter.
//   clk      : clock
//   rst      : asynchronous active-high reset (empties the buffer)
//   i_accept : store i_word and mark full
//   i_word   : word to store
//   i_pop    : entry consumed by the shifter, mark empty
//   o_full   : buffer holds a word
//   o_word   : buffered word
// ---------------------------------------------------------------------------
module mux_32_8_hold #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_accept,
    input  logic [W-1:0] i_word,
    input  logic         i_pop,
    output logic         o_full,
    output logic [W-1:0] o_word
);

    logic         r_full;
    logic [W-1:0] r_word;

    // Accept and pop never coincide: accept needs empty, pop needs full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_word <= '0;
        end else if (i_accept) begin
            r_full <= 1'b1;
            r_word <= i_word;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_word = r_word;

endmodule

// File: rtl/mux_32_8.sv
// ---------------------------------------------------------------------------
// mux_32_8
//   Transmit-side serializer: 32-bit words in via valid/ready, 8-bit bytes
//   out one per clk_4f cycle, most significant byte first. A one-word
//   holding buffer lets the next word be taken while the current one shifts.
//   clk_4f : byte-rate clock
//   reset  : asynchronous active-high reset
//   bus    : mux_32_8_if.slave (data_in/valid_in/ready_in/data_out/valid_out)
//   Build option MUX_IDLE_COM_EN: idle data_out shows the COM symbol 8'hBC
//   instead of 8'h00; valid_out timing is unchanged.
// ---------------------------------------------------------------------------
module mux_32_8
    import pci_phy_pkg::*;
(
    input  logic       clk_4f,
    input  logic       reset,
    mux_32_8_if.slave  bus
);

    localparam int unsigned NBYTES = WORD_W / BYTE_W;
    localparam int unsigned CNT_W  = $clog2(NBYTES) + 1;

`ifdef MUX_IDLE_COM_EN
    localparam logic [BYTE_W-1:0] IDLE_BYTE = COM_BYTE;
`else
    localparam logic [BYTE_W-1:0] IDLE_BYTE = IDLE_PAD;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WORD_W-1:0]   r_sr;
    logic [WORD_W-1:0]   w_sr_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [BYTE_W-1:0]   r_data_out;
    logic [BYTE_W-1:0]   w_data_nxt;
    logic                r_valid_out;
    logic                w_valid_nxt;

    logic                w_hold_full;
    logic [WORD_W-1:0]   w_hold_word;
    logic                w_accept;
    logic                w_pop;
    logic                w_last_byte;

    // ready depends only on the hold flag flop, never on valid_in
    assign bus.ready_in  = ~w_hold_full;
    assign w_accept      = bus.valid_in & ~w_hold_full;
    assign w_last_byte   = (r_cnt == CNT_W'(NBYTES));

    mux_32_8_hold #(
        .W (WORD_W)
    ) u_hold (
        .clk      (clk_4f),
        .rst      (reset),
        .i_accept (w_accept),
        .i_word   (bus.data_in),
        .i_pop    (w_pop),
        .o_full   (w_hold_full),
        .o_word   (w_hold_word)
    );

    // State, shifter, counter and output registers
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_sr        <= '0;
            r_cnt       <= '0;
            r_data_out  <= IDLE_BYTE;
            r_valid_out <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sr        <= w_sr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_data_out  <= w_data_nxt;
            r_valid_out <= w_valid_nxt;
        end
    end

    // Next-state: load a held word when idle or on the last byte, else shift or drain
    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data_out;
        w_valid_nxt = r_valid_out;
        w_pop       = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_hold_full) begin
                    w_data_nxt  = w_hold_word[WORD_W-1 -: BYTE_W];
                    w_sr_nxt    = w_hold_word << BYTE_W;
                    w_cnt_nxt   = CNT_W'(1);
                    w_valid_nxt = 1'b1;
                    w_pop       = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (!w_last_byte) begin
                    w_data_nxt  = r_sr[WORD_W-1 -: BYTE_W];
                    w_sr_nxt    = r_sr << BYTE_W;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_valid_nxt = 1'b1;
                end else if (w_hold_full) begin
                    // back-to-back word: no idle cycle between words
                    w_data_nxt  = w_hold_word[WORD_W-1 -: BYTE_W];
                    w_sr_nxt    = w_hold_word << BYTE_W;
                    w_cnt_nxt   = CNT_W'(1);
                    w_valid_nxt = 1'b1;
                    w_pop       = 1'b1;
                end else begin
                    w_data_nxt  = IDLE_BYTE;
                    w_cnt_nxt   = '0;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.data_out  = r_data_out;
    assign bus.valid_out = r_valid_out;

endmodule
